// File: rtl/listc1r3_pkg.sv
`default_nettype none
// ============================================================================
// Module  : listc1r3_pkg
// Brief   : Shared constants and state encoding for the 3x3 matrix
//           accumulator that follows the outer-product multiplier.
// Revision: 1.0 - initial release
// ============================================================================
package listc1r3_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_COL_W  = 8;

  // Nine elements of a 3x3 matrix, row-major.
  localparam int N_ELEM = 9;

  // Edges ignored after a take: upstream drops valid one cycle after it sees accept.
  localparam logic [1:0] HOLDOFF = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage : listc1r3_pkg
`default_nettype wire

// File: rtl/listc1r3_acc_lane.sv
`default_nettype none
// ============================================================================
// Module  : listc1r3_acc_lane
// Brief   : One wrapping two's-complement accumulator element with
//           synchronous clear and add-enable.
// Revision: 1.0 - initial release
// ============================================================================
module listc1r3_acc_lane
  import listc1r3_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] acc_o
);

  logic [DATA_W-1:0] acc_q;

  // Accumulate modulo 2^DATA_W; clear takes priority over add.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (add_i) begin
      acc_q <= acc_q + data_i;
    end
  end

  assign acc_o = acc_q;

endmodule : listc1r3_acc_lane
`default_nettype wire

// File: rtl/listc1r3_matacc.sv
`default_nettype none
// ============================================================================
// Module  : listc1r3_matacc
// Brief   : Accumulates NCOLS 3x3 partial products into C = sum a_k*b_k^T.
//           Upstream valid/accept with a 2-edge holdoff after each take,
//           downstream start/valid/accept, sticky column-order error.
// Revision: 1.0 - initial release
// ============================================================================
module listc1r3_matacc
  import listc1r3_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COL_W  = DEF_COL_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     matacc_start,
  input  logic [COL_W-1:0]         matacc_ncols,
  input  logic                     matacc_in_valid,
  output logic                     matacc_in_accept,
  input  logic [COL_W-1:0]         matacc_in_col,
  input  logic signed [DATA_W-1:0] matacc_in_c0,
  input  logic signed [DATA_W-1:0] matacc_in_c1,
  input  logic signed [DATA_W-1:0] matacc_in_c2,
  input  logic signed [DATA_W-1:0] matacc_in_c3,
  input  logic signed [DATA_W-1:0] matacc_in_c4,
  input  logic signed [DATA_W-1:0] matacc_in_c5,
  input  logic signed [DATA_W-1:0] matacc_in_c6,
  input  logic signed [DATA_W-1:0] matacc_in_c7,
  input  logic signed [DATA_W-1:0] matacc_in_c8,
  output logic                     matacc_valid,
  input  logic                     matacc_accept,
  output logic signed [DATA_W-1:0] matacc_out_c0,
  output logic signed [DATA_W-1:0] matacc_out_c1,
  output logic signed [DATA_W-1:0] matacc_out_c2,
  output logic signed [DATA_W-1:0] matacc_out_c3,
  output logic signed [DATA_W-1:0] matacc_out_c4,
  output logic signed [DATA_W-1:0] matacc_out_c5,
  output logic signed [DATA_W-1:0] matacc_out_c6,
  output logic signed [DATA_W-1:0] matacc_out_c7,
  output logic signed [DATA_W-1:0] matacc_out_c8,
  output logic                     matacc_err
);

  localparam logic [COL_W-1:0] C_COL_ONE = {{(COL_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [COL_W-1:0] count_q;
  logic [COL_W-1:0] ncols_q;
  logic [1:0]       holdoff_q;
  logic             err_q;
  logic             in_accept_q;
  logic             valid_q;

  logic             w_take;
  logic             w_clr;
  logic [COL_W-1:0] w_count_inc;

  logic [DATA_W-1:0] w_in  [N_ELEM];
  logic [DATA_W-1:0] w_acc [N_ELEM];

  assign w_in[0] = matacc_in_c0;
  assign w_in[1] = matacc_in_c1;
  assign w_in[2] = matacc_in_c2;
  assign w_in[3] = matacc_in_c3;
  assign w_in[4] = matacc_in_c4;
  assign w_in[5] = matacc_in_c5;
  assign w_in[6] = matacc_in_c6;
  assign w_in[7] = matacc_in_c7;
  assign w_in[8] = matacc_in_c8;

  // A partial is consumed only in ACC once the post-take holdoff has expired.
  assign w_take      = (state_q == ACC) && matacc_in_valid && (holdoff_q == 2'd0);
  assign w_clr       = (state_q == IDLE) && matacc_start;
  assign w_count_inc = count_q + C_COL_ONE;

  // Nine independent accumulator elements sharing clear and add-enable.
  for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_lane
    listc1r3_acc_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (w_clr),
      .add_i  (w_take),
      .data_i (w_in[gi]),
      .acc_o  (w_acc[gi])
    );
  end

  assign matacc_out_c0 = w_acc[0];
  assign matacc_out_c1 = w_acc[1];
  assign matacc_out_c2 = w_acc[2];
  assign matacc_out_c3 = w_acc[3];
  assign matacc_out_c4 = w_acc[4];
  assign matacc_out_c5 = w_acc[5];
  assign matacc_out_c6 = w_acc[6];
  assign matacc_out_c7 = w_acc[7];
  assign matacc_out_c8 = w_acc[8];

  // Control FSM with column counter, holdoff, error flag and registered handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      ncols_q     <= '0;
      holdoff_q   <= 2'd0;
      err_q       <= 1'b0;
      in_accept_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      in_accept_q <= w_take;
      case (state_q)
        IDLE: begin
          if (matacc_start) begin
            count_q   <= '0;
            err_q     <= 1'b0;
            ncols_q   <= matacc_ncols;
            holdoff_q <= 2'd0;
            if (matacc_ncols == '0) begin
              // Empty job: the cleared accumulators are the result.
              state_q <= FIN;
              valid_q <= 1'b1;
            end else begin
              state_q <= ACC;
            end
          end
        end
        ACC: begin
          if (w_take) begin
            count_q   <= w_count_inc;
            holdoff_q <= HOLDOFF;
            // Out-of-order column is flagged but still accumulated.
            if (matacc_in_col != count_q) begin
              err_q <= 1'b1;
            end
            if (w_count_inc == ncols_q) begin
              state_q <= FIN;
              valid_q <= 1'b1;
            end
          end else if (holdoff_q != 2'd0) begin
            holdoff_q <= holdoff_q - 2'd1;
          end
        end
        FIN: begin
          if (matacc_accept) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign matacc_in_accept = in_accept_q;
  assign matacc_valid     = valid_q;
  assign matacc_err       = err_q;

endmodule : listc1r3_matacc
`default_nettype wire
